if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 32-bit pipelined CPU.
- Owns the PC register and issues requests to instruction memory.
- Captures returned instructions into the IF/ID pipeline register.
- Feeds PC and PC+4 to the downstream 2:1 32-bit next-PC/operand select muxes.
- Takes redirects from the branch/jump resolution stage and stalls from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  input  1  stage clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
redirect_i  input  1  taken branch/jump; flush and load redirect_pc_i
redirect_pc_i  input  32  redirect target address
stall_i  input  1  ID cannot accept; IF/ID must hold
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address (word aligned)
imem_valid_i  input  1  instruction memory response valid, at least 1 cycle after request
imem_rdata_i  input  32  returned instruction word
ifid_valid_o  output  1  IF/ID contents valid
ifid_pc_o  output  32  PC of instruction in IF/ID
ifid_pc_plus4_o  output  32  ifid_pc_o + PC_STEP
ifid_instr_o  output  32  instruction in IF/ID

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low immediately forces all state, regardless of clk.
- Reset values:
  - pc_q = RESET_PC; state = BOOT.
  - imem_req_o = 0; imem_addr_o = RESET_PC.
  - ifid_valid_o = 0; ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o = 0.
  - Hold buffer empty.
- States: BOOT, FETCH, HOLD, DRAIN.
- BOOT: one cycle after rst_n deasserts, then go to FETCH. imem_req_o = 0.
- FETCH:
  - imem_req_o = 1; imem_addr_o = pc_q, stable until imem_valid_i.
  - Response with no stall and no redirect:
    - IF/ID <= {1, pc_q, pc_q+PC_STEP, imem_rdata_i}.
    - pc_q <= pc_q + PC_STEP; stay in FETCH.
  - No response and no stall: ifid_valid_o <= 0 (bubble).
- Response while stall_i = 1 (no redirect):
  - IF/ID holds.
  - Response goes into the hold buffer {pc_q, rdata}; pc_q <= pc_q + PC_STEP.
  - Next state HOLD; imem_req_o = 0.
- HOLD:
  - No request issued; IF/ID holds while stall_i = 1.
  - First cycle with stall_i = 0: IF/ID <= hold buffer (valid = 1); buffer emptied; go to FETCH.
  - Minimum stall-to-resume latency is 1 cycle.
- Redirect (redirect_i = 1) has highest priority in every state and overrides stall_i:
  - ifid_valid_o <= 0; ifid_instr_o <= NOP_INSTR.
  - Hold buffer cleared.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - If a request is outstanding and imem_valid_i = 0 this cycle: go to DRAIN.
  - Otherwise (including a same-cycle response, which is discarded): go to FETCH.
- DRAIN:
  - imem_req_o = 0; wait for imem_valid_i and discard that response; then go to FETCH.
  - A further redirect in DRAIN updates pc_q and stays in DRAIN.
- Stall with no response and no redirect: IF/ID holds and the request stays asserted.
- Arithmetic is modulo 2^32: pc_q = 32'hFFFF_FFFC plus 4 gives 32'h0000_0000; ifid_pc_plus4_o wraps the same way.
- Reset mid-request: outstanding request abandoned and imem_req_o drops asynchronously. Memory is reset by the same rst_n.
- Outputs are registered; no combinational path from imem_rdata_i to the ifid_* outputs.

Decomposition:
- Shared package cpu_pkg:
  - XLEN = 32.
  - NOP_INSTR = 32'h0000_0000.
  - PC_ALIGN_MASK = 32'hFFFF_FFFC.
  - Enum fetch_state_t {BOOT, FETCH, HOLD, DRAIN}.
- One natural sub-module: if_pc_reg, the PC register with reset, load (redirect), increment and hold enables.
- FSM, hold buffer and IF/ID register stay in the top module.

Test Plan:
- Reset release, memory replies 1 cycle after each request with 0x11,0x22,0x33 -> ifid_pc_o 0x0,0x4,0x8 with matching instr; ifid_valid_o high from the 3rd cycle after rst_n rises.
- Response 0xAA at PC 0x8 while stall_i held 3 cycles -> IF/ID frozen, imem_req_o = 0 during HOLD; 1 cycle after stall drops, IF/ID = {0x8, 0xC, 0xAA}; next request to 0xC.
- redirect_i with redirect_pc_i = 0x100 while a request is pending -> ifid_valid_o = 0 next cycle; DRAIN discards the late response; next request address = 0x100.
- redirect_i in the same cycle as a response and stall_i = 1 -> response dropped, IF/ID invalid with NOP_INSTR, next address = target; redirect_pc_i = 0x103 fetches 0x100.
- RESET_PC = 0xFFFF_FFFC -> first IF/ID shows pc_plus4 = 0x0; second fetch address = 0x0.
- rst_n pulsed low mid-HOLD -> all outputs at reset values immediately without a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 32-bit pipelined CPU.
// Used by the fetch stage and its PC register.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    // A fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: a load (redirect) beats an increment.
// With neither enable asserted the PC holds.
module if_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic            incr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_seq_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Wraps modulo 2^32, so the address after 0xFFFF_FFFC is 0.
    assign pc_next_seq_o = pc_q + XLEN'(PC_STEP);
    assign pc_o          = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = align_pc(load_pc_i);
        end else if (incr_i) begin
            pc_d = pc_next_seq_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC sequencing, instruction-memory handshake,
// one-entry hold buffer for stalled responses and the IF/ID register.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_valid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc_plus4_o,
    output logic [XLEN-1:0] ifid_instr_o
);

    fetch_state_t    state_q, state_d;
    fetch_entry_t    hold_q, hold_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;

    logic            pc_load;
    logic            pc_incr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next_seq;

    if_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (pc_load),
        .load_pc_i     (redirect_pc_i),
        .incr_i        (pc_incr),
        .pc_o          (pc),
        .pc_next_seq_o (pc_next_seq)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d         = state_q;
        hold_d          = hold_q;
        ifid_valid_d    = ifid_valid_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        pc_load         = 1'b0;
        pc_incr         = 1'b0;

        if (redirect_i) begin
            pc_load      = 1'b1;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            hold_d       = '0;
            // A request still owed by memory must be swallowed before refetching.
            if ((state_q == FETCH || state_q == DRAIN) && !imem_valid_i) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                BOOT: state_d = FETCH;
                FETCH: begin
                    if (imem_valid_i) begin
                        pc_incr = 1'b1;
                        if (stall_i) begin
                            hold_d  = '{pc: pc, instr: imem_rdata_i};
                            state_d = HOLD;
                        end else begin
                            ifid_valid_d    = 1'b1;
                            ifid_pc_d       = pc;
                            ifid_pc_plus4_d = pc_next_seq;
                            ifid_instr_d    = imem_rdata_i;
                        end
                    end else if (!stall_i) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        ifid_valid_d    = 1'b1;
                        ifid_pc_d       = hold_q.pc;
                        ifid_pc_plus4_d = hold_q.pc + XLEN'(PC_STEP);
                        ifid_instr_d    = hold_q.instr;
                        hold_d          = '0;
                        state_d         = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid_i) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= BOOT;
            hold_q          <= '0;
            ifid_valid_q    <= 1'b0;
            ifid_pc_q       <= '0;
            ifid_pc_plus4_q <= '0;
            ifid_instr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // pre-edge values, independent of statement order.
            state_q         <= state_d;
            hold_q          <= hold_d;
            ifid_valid_q    <= ifid_valid_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
        end
    end

    // The request is decoded from the state register, so reset drops it at once.
    assign imem_req_o      = (state_q == FETCH);
    assign imem_addr_o     = pc;
    assign ifid_valid_o    = ifid_valid_q;
    assign ifid_pc_o       = ifid_pc_q;
    assign ifid_pc_plus4_o = ifid_pc_plus4_q;
    assign ifid_instr_o    = ifid_instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus4_o;
    logic [31:0] ifid_instr_o;

    logic        rst_w_n;
    logic        req_w;
    logic [31:0] addr_w;
    logic        valid_w;
    logic [31:0] rdata_w;
    logic        ifid_valid_w;
    logic [31:0] ifid_pc_w;
    logic [31:0] ifid_pc4_w;
    logic [31:0] ifid_instr_w;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .stall_i         (stall_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_valid_i    (imem_valid_i),
        .imem_rdata_i    (imem_rdata_i),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_pc_plus4_o (ifid_pc_plus4_o),
        .ifid_instr_o    (ifid_instr_o)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk             (clk),
        .rst_n           (rst_w_n),
        .redirect_i      (1'b0),
        .redirect_pc_i   (32'h0),
        .stall_i         (1'b0),
        .imem_req_o      (req_w),
        .imem_addr_o     (addr_w),
        .imem_valid_i    (valid_w),
        .imem_rdata_i    (rdata_w),
        .ifid_valid_o    (ifid_valid_w),
        .ifid_pc_o       (ifid_pc_w),
        .ifid_pc_plus4_o (ifid_pc4_w),
        .ifid_instr_o    (ifid_instr_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    bit          m_booted;
    bit          m_discard;
    ent_t        m_hold[$];
    logic [31:0] m_pc;
    bit          m_v;
    logic [31:0] m_ipc, m_ipc4, m_instr;

    function automatic bit m_req();
        return m_booted && !m_discard && (m_hold.size() == 0);
    endfunction

    task automatic model_reset();
        m_booted  = 0;
        m_discard = 0;
        m_hold.delete();
        m_pc      = 32'h0;
        m_v       = 0;
        m_ipc     = 0;
        m_ipc4    = 0;
        m_instr   = 0;
    endtask

    task automatic model_step(input bit redir, input logic [31:0] rpc, input bit stall,
                              input bit v, input logic [31:0] rd);
        bit   owed;
        ent_t e;
        owed = m_booted && (m_hold.size() == 0);
        if (redir) begin
            m_v       = 0;
            m_instr   = 32'h0;
            m_hold.delete();
            m_pc      = {rpc[31:2], 2'b00};
            m_discard = owed && !v;
            m_booted  = 1;
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (m_discard) begin
            if (v) m_discard = 0;
        end else if (m_hold.size() != 0) begin
            if (!stall) begin
                e = m_hold.pop_front();
                m_v = 1; m_ipc = e.pc; m_ipc4 = e.pc + 32'd4; m_instr = e.instr;
            end
        end else if (v) begin
            if (stall) begin
                e.pc = m_pc; e.instr = rd;
                m_hold.push_back(e);
            end else begin
                m_v = 1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = rd;
            end
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_v = 0;
        end
    endtask

    task automatic compare_model();
        check("req",   32'(imem_req_o),   32'(m_req()));
        check("addr",  imem_addr_o,       m_pc);
        check("valid", 32'(ifid_valid_o), 32'(m_v));
        check("pc",    ifid_pc_o,         m_ipc);
        check("pc4",   ifid_pc_plus4_o,   m_ipc4);
        check("instr", ifid_instr_o,      m_instr);
    endtask

    // ---------------- memory model ----------------
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          lat_q[$];
    logic [31:0] data_q[$];

    task automatic mem_drive();
        imem_valid_i = 1'b0;
        imem_rdata_i = $urandom;
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_valid_i = 1'b1;
                imem_rdata_i = mem_data;
                mem_pending  = 0;
            end
        end else if (imem_req_o) begin
            mem_pending = 1;
            mem_cnt     = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(1, 3));
            mem_data    = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
        end
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit stall);
        mem_drive();
        redirect_i    = redir;
        redirect_pc_i = rpc;
        stall_i       = stall;
        model_step(redir, rpc, stall, imem_valid_i, imem_rdata_i);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        redirect_i   = 1'b0;
        stall_i      = 1'b0;
        imem_valid_i = 1'b0;
        mem_pending  = 0;
        lat_q.delete();
        data_q.delete();
        model_reset();
        #1;
        compare_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rst_w_n = 1'b0;
        redirect_i = 0; redirect_pc_i = 0; stall_i = 0;
        imem_valid_i = 0; imem_rdata_i = 0; valid_w = 0; rdata_w = 0;
        model_reset();

        // Reset PC at the top of the address space wraps PC+4 to zero.
        @(posedge clk); #1;
        check("wrap_rst_req",  32'(req_w), 32'h0);
        check("wrap_rst_addr", addr_w,     32'hFFFF_FFFC);
        rst_w_n = 1'b1;
        @(posedge clk); #1;
        check("wrap_req1",  32'(req_w), 32'h1);
        check("wrap_addr1", addr_w,     32'hFFFF_FFFC);
        @(posedge clk); #1;
        valid_w = 1'b1; rdata_w = 32'h55;
        @(posedge clk); #1;
        valid_w = 1'b0;
        check("wrap_valid", 32'(ifid_valid_w), 32'h1);
        check("wrap_pc",    ifid_pc_w,         32'hFFFF_FFFC);
        check("wrap_pc4",   ifid_pc4_w,        32'h0);
        check("wrap_instr", ifid_instr_w,      32'h55);
        check("wrap_addr2", addr_w,            32'h0);

        // Sequential fetch, memory answering one cycle after each request.
        do_reset();
        lat_q  = '{1, 1, 1};
        data_q = '{32'h11, 32'h22, 32'h33};
        cycle(0, 0, 0);
        check("a_req_after_boot", 32'(imem_req_o), 32'h1);
        cycle(0, 0, 0);
        check("a_valid_e2", 32'(ifid_valid_o), 32'h0);
        cycle(0, 0, 0);
        check("a_valid_e3", 32'(ifid_valid_o), 32'h1);
        check("a_pc0",      ifid_pc_o,         32'h0);
        check("a_instr0",   ifid_instr_o,      32'h11);
        repeat (2) cycle(0, 0, 0);
        check("a_pc1",      ifid_pc_o,         32'h4);
        check("a_instr1",   ifid_instr_o,      32'h22);
        repeat (2) cycle(0, 0, 0);
        check("a_pc2",      ifid_pc_o,         32'h8);
        check("a_pc4_2",    ifid_pc_plus4_o,   32'hC);
        check("a_instr2",   ifid_instr_o,      32'h33);

        // Asynchronous reset while a stalled response sits in the hold buffer.
        do_reset();
        lat_q  = '{1, 1};
        data_q = '{32'h11, 32'h22};
        repeat (3) cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        check("d_hold_req", 32'(imem_req_o), 32'h0);
        check("d_hold_ifid_instr", ifid_instr_o, 32'h11);
        rst_n = 1'b0;
        #1;
        check("d_rst_req",   32'(imem_req_o),   32'h0);
        check("d_rst_addr",  imem_addr_o,       32'h0);
        check("d_rst_valid", 32'(ifid_valid_o), 32'h0);
        check("d_rst_pc4",   ifid_pc_plus4_o,   32'h0);
        check("d_rst_instr", ifid_instr_o,      32'h0);
        do_reset();
        cycle(0, 0, 0);
        check("d_restart_req",  32'(imem_req_o), 32'h1);
        check("d_restart_addr", imem_addr_o,     32'h0);

        // Response at 0x8 arrives while stalled; stall held three cycles.
        do_reset();
        lat_q  = '{1, 1, 1};
        data_q = '{32'h11, 32'h22, 32'hAA};
        repeat (6) cycle(0, 0, 0);
        repeat (3) begin
            cycle(0, 0, 1);
            check("b_hold_req",   32'(imem_req_o), 32'h0);
            check("b_hold_pc",    ifid_pc_o,       32'h4);
            check("b_hold_instr", ifid_instr_o,    32'h22);
        end
        cycle(0, 0, 0);
        check("b_resume_valid", 32'(ifid_valid_o), 32'h1);
        check("b_resume_pc",    ifid_pc_o,         32'h8);
        check("b_resume_pc4",   ifid_pc_plus4_o,   32'hC);
        check("b_resume_instr", ifid_instr_o,      32'hAA);
        check("b_resume_addr",  imem_addr_o,       32'hC);

        // Redirect with a request pending, then redirect on a stalled response.
        do_reset();
        lat_q  = '{3, 1, 1};
        data_q = '{32'hDEAD_BEEF, 32'hBB, 32'hCC};
        cycle(0, 0, 0);
        cycle(1, 32'h100, 0);
        check("c_redir_valid", 32'(ifid_valid_o), 32'h0);
        check("c_drain_req",   32'(imem_req_o),   32'h0);
        repeat (2) cycle(0, 0, 0);
        check("c_drain_req2",  32'(imem_req_o),   32'h0);
        cycle(0, 0, 0);
        check("c_refetch_req",  32'(imem_req_o), 32'h1);
        check("c_refetch_addr", imem_addr_o,     32'h100);
        repeat (2) cycle(0, 0, 0);
        check("c_tgt_pc",    ifid_pc_o,    32'h100);
        check("c_tgt_instr", ifid_instr_o, 32'hBB);
        cycle(0, 0, 0);
        cycle(1, 32'h103, 1);
        check("c_flush_valid", 32'(ifid_valid_o), 32'h0);
        check("c_flush_instr", ifid_instr_o,      32'h0);
        check("c_flush_req",   32'(imem_req_o),   32'h1);
        check("c_flush_addr",  imem_addr_o,       32'h100);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          rd;
            bit          st;
            logic [31:0] tgt;
            if (i % 1000 == 999) begin
                do_reset();
            end else begin
                rd  = ($urandom_range(0, 11) == 0);
                st  = ($urandom_range(0, 2) == 0);
                tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                  : 32'($urandom);
                cycle(rd, tgt, st);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
